// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller and its CPU-side users.
// Holds the memory geometry, the controller state type, the request record
// and the address range helper used when DMEM_BOUNDS_CHECK_EN is defined.
package dmem_pkg;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 16384;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } dmem_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    // True when the word address falls inside the implemented memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < 32'(MEM_DEPTH));
    endfunction

endpackage

// File: rtl/dmem_access_ctrl.sv
// CPU-side initiator for the 16K x 16 data memory.
// Turns single load/store requests into memory cycles, hides the one-cycle
// registered read latency and returns results on a valid/ready channel.
// Optional macro DMEM_BOUNDS_CHECK_EN: out-of-range requests are answered
// directly with rsp_err=1 and never reach the memory.
module dmem_access_ctrl
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_initialize,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    dmem_state_t       state_q, state_d;
    dmem_req_t         req_q, req_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic              mem_initialize_q, mem_initialize_d;
    logic              mem_load_q, mem_load_d;

    logic              req_ready_s;
    logic              accept_s;
    logic              req_oor_s;

    // Acceptance only in IDLE, never when a preload is requested, never in reset.
    assign req_ready_s = rst_n && (state_q == ST_IDLE) && !init_req;
    assign accept_s    = req_valid && req_ready_s;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_oor_s = !addr_in_range(req_addr);
`else
    assign req_oor_s = 1'b0;
`endif

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        rsp_rdata_d      = rsp_rdata_q;
        rsp_err_d        = rsp_err_q;
        mem_initialize_d = 1'b0;
        mem_load_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d          = ST_INIT;
                    mem_initialize_d = 1'b1;
                end else if (accept_s) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    if (req_oor_s) begin
                        // Answer immediately; the memory is never touched.
                        state_d     = ST_RESP;
                        rsp_rdata_d = {DATA_W{1'b0}};
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_ISSUE;
                        rsp_err_d  = 1'b0;
                        mem_load_d = req_write;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (req_q.write) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = {DATA_W{1'b0}};
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Registered memory data is valid during this cycle.
                rsp_rdata_d = mem_out;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, captured request and registered outputs; reset drops any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            req_q            <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= {DATA_W{1'b0}};
            rsp_err_q        <= 1'b0;
            busy_q           <= 1'b0;
            mem_initialize_q <= 1'b0;
            mem_load_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            rsp_err_q        <= rsp_err_d;
            busy_q           <= busy_d;
            mem_initialize_q <= mem_initialize_d;
            mem_load_q       <= mem_load_d;
        end
    end

    assign req_ready      = req_ready_s;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
`ifdef DMEM_BOUNDS_CHECK_EN
    assign rsp_err        = rsp_err_q;
`else
    assign rsp_err        = 1'b0 & rsp_err_q;
`endif
    assign busy           = busy_q;
    assign mem_initialize = mem_initialize_q;
    assign mem_load       = mem_load_q;
    // The captured request register drives the port and holds between cycles.
    assign mem_address    = req_q.addr;
    assign mem_in         = req_q.wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural memory and a
// reference model of the expected memory contents.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_req;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              mem_initialize;
    logic              mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] ref_mem [int];

    always #5 clk = ~clk;

    dmem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .mem_initialize(mem_initialize), .mem_load(mem_load),
        .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out)
    );

    // Data memory: preload writes i+1, 14-bit address decode, registered read.
    always @(posedge clk) begin
        if (mem_initialize) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 16'(i + 1);
        end else if (mem_load) begin
            mem[mem_address[13:0]] <= mem_in;
        end
        mem_out <= mem[mem_address[13:0]];
    end

    function automatic logic [DATA_W-1:0] ref_read(input int a);
        int idx;
        idx = a % MEM_DEPTH;
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return 16'(idx + 1);
    endfunction

    function automatic bit ref_err(input int a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (a >= MEM_DEPTH);
`else
        return (a < 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction with latency, data, error and handshake checks.
    task automatic xact(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int hold);
        logic [DATA_W-1:0] exp_rd;
        bit  exp_err;
        int  exp_lat;
        int  n;
        bit  saw_load;
        bit  both;
        exp_err = ref_err(int'(a));
        exp_rd  = (w || exp_err) ? 16'h0000 : ref_read(int'(a));
        exp_lat = exp_err ? 1 : (w ? 2 : 3);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1; saw_load = 1'b0; both = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_load) saw_load = 1'b1;
            if (mem_load && mem_initialize) both = 1'b1;
            if (rsp_valid) break;
            @(posedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".mem_load"}, 32'(saw_load), 32'(w && !exp_err));
        chk({tag, ".load_and_init"}, 32'(both), 32'd0);
        chk({tag, ".rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, ".ready_in_resp"}, 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
            chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".after_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".after_ready"}, 32'(req_ready), 32'd1);
        if (w && !exp_err) ref_mem[int'(a) % MEM_DEPTH] = d;
    endtask

    initial begin
        bit seen;
        logic          rw;
        logic [ADDR_W-1:0] ra;
        rst_n = 1'b0; init_req = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

        // Reset state.
        #2;
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.mem_port", {mem_initialize, mem_load, mem_address}, 32'd0);
        chk("rst.mem_in", 32'(mem_in), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle.req_ready", 32'(req_ready), 32'd1);
        chk("idle.mem_port", {mem_initialize, mem_load, mem_address}, 32'd0);

        // Preload request together with a load: preload wins, load follows.
        @(negedge clk);
        init_req = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0001;
        #1;
        chk("init.req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        init_req = 1'b0;
        chk("init.pulse", {mem_initialize, mem_load}, 32'd2);
        chk("init.busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        ref_mem.delete();
        chk("init.one_cycle", 32'(mem_initialize), 32'd0);
        chk("init.ready_after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("init.accepted", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init.load1_valid", 32'(rsp_valid), 32'd1);
        chk("init.load1_rdata", 32'(rsp_rdata), 32'h0002);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        xact("load2", 1'b0, 15'h0002, 16'h0000, 0);

        // Store then load back, with the response held off for five cycles.
        xact("st5", 1'b1, 15'h0005, 16'hBEEF, 0);
        xact("ld5_hold", 1'b0, 15'h0005, 16'h0000, 5);

        // Out-of-range address: aliases, or is rejected when bounds checking is built in.
        xact("st4001", 1'b1, 15'h4001, 16'h1234, 0);
        xact("ld1", 1'b0, 15'h0001, 16'h0000, 0);

        // Reset during the ISSUE cycle of a store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0007; req_wdata = 16'hAAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid.load_high", 32'(mem_load), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.load_drop", 32'(mem_load), 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rstmid.no_rsp", 32'(seen), 32'd0);
        xact("ld7", 1'b0, 15'h0007, 16'h0000, 0);

        // Randomized mix of loads and stores against the reference model.
        for (int r = 0; r < 24; r++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ra = 15'($urandom_range(0, 32767));
            else ra = 15'($urandom_range(0, 15));
            xact(rw ? "rnd_st" : "rnd_ld", rw, ra, 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
CPU-side initiator for the 16K x 16 data memory; owns the memory port (address, write data, write enable, preload trigger) and turns single CPU load/store requests into correctly timed memory cycles. It absorbs the memory's one-cycle registered read latency and returns results over a valid/ready response channel. It sits between the CPU datapath/control and the data memory, and is the only driver of the memory port.

Parameters:
ADDR_W, 15, request/memory address width
DATA_W, 16, data word width
MEM_DEPTH, 16384, number of implemented words; upper bound for the optional bounds check

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
init_req  in  1  one-cycle request to fire the memory preload
req_valid  in  1  CPU request present
req_ready  out  1  controller can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  response present
rsp_ready  in  1  CPU accepts response
rsp_rdata  out  DATA_W  load result; 0 for stores
rsp_err  out  1  address-range error; constant 0 when the optional feature is absent
busy  out  1  high in any state other than IDLE
mem_initialize  out  1  memory preload trigger
mem_load  out  1  memory write enable
mem_address  out  ADDR_W  memory address
mem_in  out  DATA_W  memory write data
mem_out  in  DATA_W  memory registered read data

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n is low, state is IDLE and every registered output (rsp_valid, rsp_rdata, rsp_err, mem_*, busy) is 0. req_ready is forced to 0 while rst_n is low.
- States: IDLE, INIT, ISSUE, WAIT, RESP.
- req_ready = (state==IDLE) && !init_req. A request is accepted when req_valid && req_ready at a rising edge; the request fields are captured into registers on that edge.
- IDLE:
  - init_req has priority over req_valid.
  - init_req=1 -> INIT.
  - Accepted request -> ISSUE.
- INIT: mem_initialize=1 for exactly one cycle, mem_load=0; next state IDLE. init_req arriving outside IDLE is ignored (no queueing).
- ISSUE:
  - mem_address and mem_in are driven from the captured registers.
  - Store: mem_load=1 this cycle only, then RESP.
  - Load: mem_load=0, then WAIT.
- WAIT: memory output is valid this cycle; mem_out is captured into rsp_rdata at the end of the cycle; next state RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready, then IDLE.
  - rsp_rdata=0 for stores.
- Latency from the accept edge: store response visible 2 cycles later, load response 3 cycles later. With rsp_ready tied high, throughput is 1 request per 3 (store) or 4 (load) cycles.
- Invariants:
  - mem_load and mem_initialize are never both 1.
  - mem_load is never 1 outside ISSUE.
  - mem_address holds its last value in IDLE/RESP (no glitching to 0).
- Address handling: no arithmetic. Without the bounds check, the memory itself truncates the address to 14 bits, so 0x4000 aliases to 0x0000.
- Back-to-back: a new request cannot be accepted in the same cycle a response completes; acceptance resumes in the following IDLE cycle.
- Reset mid-operation: the transaction is dropped, no response is issued, and mem_load falls immediately (asynchronously).

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: an accepted request with req_addr >= MEM_DEPTH skips ISSUE/WAIT and goes directly IDLE -> RESP on the next edge, with rsp_err=1, rsp_rdata=0 and mem_load never asserted.
- Undefined: no check, rsp_err tied to 0, out-of-range addresses alias in memory.

Decomposition:
- Shared package dmem_pkg holds:
  - ADDR_W, DATA_W, MEM_DEPTH constants
  - state enum type dmem_state_t
  - a request struct {write, addr, wdata}, reused by the CPU control unit
- No sub-module; a single FSM with a captured-request register is natural.

Test Plan:
- Reset then idle -> req_ready=1, all mem_* = 0, rsp_valid=0; assert rst_n low mid-ISSUE store -> mem_load drops at once, no response after release.
- Store addr=0x0005 data=0xBEEF, then load addr=0x0005 -> store rsp_valid 2 cycles after accept; load rsp_rdata=0xBEEF 3 cycles after accept.
- init_req and req_valid asserted in the same cycle -> mem_initialize=1 for one cycle, mem_load=0, request accepted one cycle later; load addr=1 returns 0x0002, addr=2 returns 0x0003.
- Load with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable all 5 cycles, req_ready=0 until the handshake completes.
- Store addr=0x4001 data=0x1234 without the macro -> load addr=0x0001 returns 0x1234, rsp_err=0; with DMEM_BOUNDS_CHECK_EN -> rsp_err=1 one cycle after accept, mem_load never high, addr 0x0001 unchanged.
